// File: rtl/wb.sv
// Write-back stage: retires ALU results immediately, waits on the memory response for loads, drives the regfile write port.
// Latency 1 cycle from retire condition to write strobe; o_stall holds upstream while a load response is outstanding.

`ifndef WB_DEFS_SV
`define WB_DEFS_SV
`define ADDR_W       32
`define INSTR_W      32
`define DEST_SRC_W   2
`define DEST_SRC_ALU 2'd1
`define DEST_SRC_MEM 2'd2
`define REG_IDX_W    5
`define WORD_W       32
`endif

module wb #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   i_valid,
    input  logic [`ADDR_W-1:0]     i_pc,
    input  logic [`INSTR_W-1:0]    i_instr,
    input  logic [`DEST_SRC_W-1:0] i_dest_src,
    input  logic [`REG_IDX_W-1:0]  i_dest_reg,
    input  logic [`WORD_W-1:0]     i_alu_result,
    input  logic                   i_mem_rsp_valid,
    input  logic [`WORD_W-1:0]     i_mem_rsp_data,
    output logic                   o_mem_rsp_ready,
    output logic                   o_stall,
    output logic                   o_wb_dest_en,
    output logic [`REG_IDX_W-1:0]  o_wb_dest_reg,
    output logic [`WORD_W-1:0]     o_wb_dest_data,
    output logic [CNT_W-1:0]       o_retired,
    output logic                   o_timeout
);
    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                  state, state_n;
    logic [TW-1:0]           timer, timer_n;
    logic [`REG_IDX_W-1:0]   l_reg;
    logic [2:0]              l_f3;
    logic [1:0]              l_off;
    logic                    latch, retire, wr, to_set;
    logic [`REG_IDX_W-1:0]   wr_reg;
    logic [`WORD_W-1:0]      wr_val;
    logic                    wr_fire;

    // Misaligned halfwords select by off[1] only; unknown funct3 passes the word through.
    function automatic logic [`WORD_W-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [`WORD_W-1:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = d[16*off[1] +: 16];
        case (f3)
            3'b000:  extract = {{24{b[7]}}, b};
            3'b100:  extract = {24'd0, b};
            3'b001:  extract = {{16{h[15]}}, h};
            3'b101:  extract = {16'd0, h};
            default: extract = d;
        endcase
    endfunction

    always_comb begin
        state_n         = state;
        timer_n         = timer;
        o_mem_rsp_ready = 1'b0;
        o_stall         = 1'b0;
        latch           = 1'b0;
        retire          = 1'b0;
        wr              = 1'b0;
        to_set          = 1'b0;
        wr_reg          = i_dest_reg;
        wr_val          = i_alu_result;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (i_dest_src == `DEST_SRC_MEM) begin
                        o_mem_rsp_ready = 1'b1;
                        if (i_mem_rsp_valid) begin
                            retire = 1'b1;
                            wr     = 1'b1;
                            wr_val = extract(i_instr[14:12], i_alu_result[1:0], i_mem_rsp_data);
                        end else begin
                            o_stall = 1'b1;
                            latch   = 1'b1;
                            timer_n = TW'(1);
                            state_n = WAIT_MEM;
                        end
                    end else begin
                        retire = 1'b1;
                        wr     = (i_dest_src == `DEST_SRC_ALU);
                    end
                end
            end
            WAIT_MEM: begin
                o_mem_rsp_ready = 1'b1;
                wr_reg          = l_reg;
                if (i_mem_rsp_valid) begin
                    retire  = 1'b1;
                    wr      = 1'b1;
                    wr_val  = extract(l_f3, l_off, i_mem_rsp_data);
                    state_n = IDLE;
                end else if (MEM_TIMEOUT != 0 && timer == TW'(MEM_TIMEOUT)) begin
                    to_set  = 1'b1;
                    state_n = IDLE;
                end else begin
                    o_stall = 1'b1;
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign wr_fire = retire && wr && (wr_reg != '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state          <= IDLE;
            timer          <= '0;
            l_reg          <= '0;
            l_f3           <= '0;
            l_off          <= '0;
            o_wb_dest_en   <= 1'b0;
            o_wb_dest_reg  <= '0;
            o_wb_dest_data <= '0;
            o_retired      <= '0;
            o_timeout      <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            o_wb_dest_en <= wr_fire;
            if (latch) begin
                l_reg <= i_dest_reg;
                l_f3  <= i_instr[14:12];
                l_off <= i_alu_result[1:0];
            end
            if (wr_fire) begin
                o_wb_dest_reg  <= wr_reg;
                o_wb_dest_data <= wr_val;
            end
            if (retire)
                o_retired <= o_retired + CNT_W'(1);
            if (to_set)
                o_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb.sv
// Bench for wb: directed vector table, reset-during-wait sequence, then randomized transactions against a load model.
module tb_wb;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [1:0] S_NONE = 2'd0;
    localparam logic [1:0] S_ALU  = 2'd1;
    localparam logic [1:0] S_MEM  = 2'd2;

    logic        clk = 1'b0;
    logic        clr, i_valid, i_mem_rsp_valid;
    logic [31:0] i_pc, i_instr, i_alu_result, i_mem_rsp_data;
    logic [1:0]  i_dest_src;
    logic [4:0]  i_dest_reg;
    logic        o_mem_rsp_ready, o_stall, o_wb_dest_en, o_timeout;
    logic [4:0]  o_wb_dest_reg;
    logic [31:0] o_wb_dest_data;
    logic [CW-1:0] o_retired;

    always #5 clk = ~clk;

    wb #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .i_valid(i_valid), .i_pc(i_pc), .i_instr(i_instr),
        .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg), .i_alu_result(i_alu_result),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data),
        .o_mem_rsp_ready(o_mem_rsp_ready), .o_stall(o_stall), .o_wb_dest_en(o_wb_dest_en),
        .o_wb_dest_reg(o_wb_dest_reg), .o_wb_dest_data(o_wb_dest_data),
        .o_retired(o_retired), .o_timeout(o_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view of the write port: what the regfile should have seen so far.
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_ret;
    logic        m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * off)) & 32'hFF;
        h = (d >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    task automatic model_reset();
        m_reg = '0; m_data = '0; m_ret = 0; m_to = 1'b0;
    endtask

    task automatic check_regs(input logic exp_en);
        logic [CW-1:0] r;
        r = m_ret[CW-1:0];
        chk("en", {31'd0, o_wb_dest_en}, {31'd0, exp_en});
        chk("dest_reg", {27'd0, o_wb_dest_reg}, {27'd0, m_reg});
        chk("dest_data", o_wb_dest_data, m_data);
        chk("retired", {{(32-CW){1'b0}}, o_retired}, {{(32-CW){1'b0}}, r});
        chk("timeout", {31'd0, o_timeout}, {31'd0, m_to});
    endtask

    task automatic do_reset();
        clr = 1'b1; i_valid = 1'b0; i_mem_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic idle_cycle();
        i_valid = 1'b0; i_dest_src = 2'($urandom); i_mem_rsp_valid = 1'($urandom);
        i_mem_rsp_data = $urandom;
        #1;
        chk("idle_ready", {31'd0, o_mem_rsp_ready}, 32'd0);
        chk("idle_stall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        check_regs(1'b0);
    endtask

    // One instruction; a load's response arrives d cycles after issue (0 = same cycle).
    task automatic run_txn(input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] data, input int d);
        logic is_mem, timed_out, exp_en;
        int last;
        is_mem    = (src == S_MEM);
        last      = !is_mem ? 0 : ((d < TO) ? d : TO);
        timed_out = is_mem && (d > TO);
        for (int c = 0; c <= last; c++) begin
            if (c == 0) begin
                i_valid = 1'b1; i_dest_src = src; i_dest_reg = rd; i_alu_result = alu;
                i_instr = $urandom; i_instr[14:12] = f3; i_pc = $urandom;
            end else begin
                i_valid = 1'($urandom); i_dest_src = 2'($urandom); i_dest_reg = 5'($urandom);
                i_alu_result = $urandom; i_instr = $urandom; i_pc = $urandom;
            end
            i_mem_rsp_valid = is_mem ? (c == d) : 1'($urandom);
            i_mem_rsp_data  = (is_mem && c == d) ? data : $urandom;
            #1;
            chk("stall", {31'd0, o_stall}, {31'd0, (is_mem && c != last)});
            if (is_mem) chk("ready", {31'd0, o_mem_rsp_ready}, 32'd1);
            @(negedge clk);
            if (c != last) chk("en_wait", {31'd0, o_wb_dest_en}, 32'd0);
        end
        exp_en = 1'b0;
        if (timed_out) begin
            m_to = 1'b1;
        end else begin
            m_ret = (m_ret + 1) % (1 << CW);
            if ((src == S_ALU || src == S_MEM) && rd != 0) begin
                exp_en = 1'b1;
                m_reg  = rd;
                m_data = is_mem ? ref_load(f3, alu[1:0], data) : alu;
            end
        end
        i_valid = 1'b0; i_mem_rsp_valid = 1'b0;
        check_regs(exp_en);
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] data;
        int          d;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{S_ALU,  3'b000, 5'd5,  32'h1234_5678, 32'h0,          0,  1'b1, 32'h1234_5678};
        vecs[1] = '{S_ALU,  3'b000, 5'd0,  32'hDEAD_BEEF, 32'h0,          0,  1'b0, 32'h1234_5678};
        vecs[2] = '{S_MEM,  3'b000, 5'd7,  32'h0000_1003, 32'h8000_0000,  0,  1'b1, 32'hFFFF_FF80};
        vecs[3] = '{S_MEM,  3'b101, 5'd8,  32'h0000_2002, 32'hABCD_0000,  3,  1'b1, 32'h0000_ABCD};
        vecs[4] = '{S_MEM,  3'b010, 5'd9,  32'h0000_3000, 32'h1111_1111,  10, 1'b0, 32'h0000_ABCD};
        vecs[5] = '{S_MEM,  3'b001, 5'd10, 32'h0000_0003, 32'h8765_4321,  1,  1'b1, 32'hFFFF_8765};
        vecs[6] = '{S_MEM,  3'b100, 5'd11, 32'h0000_0001, 32'h0000_F200,  4,  1'b1, 32'h0000_00F2};
        vecs[7] = '{S_NONE, 3'b000, 5'd12, 32'h5555_5555, 32'h0,          0,  1'b0, 32'h0000_00F2};
        vecs[8] = '{S_MEM,  3'b111, 5'd13, 32'h0000_0002, 32'hCAFE_BABE,  2,  1'b1, 32'hCAFE_BABE};
        vecs[9] = '{S_MEM,  3'b000, 5'd14, 32'h0000_0001, 32'h0000_7F00,  0,  1'b1, 32'h0000_007F};

        clr = 1'b1; i_valid = 1'b0; i_pc = '0; i_instr = '0; i_dest_src = '0; i_dest_reg = '0;
        i_alu_result = '0; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
        @(negedge clk);
        do_reset();
        check_regs(1'b0);

        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].src, vecs[i].f3, vecs[i].rd, vecs[i].alu, vecs[i].data, vecs[i].d);
            chk($sformatf("vec%0d_en", i), {31'd0, o_wb_dest_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("vec%0d_data", i), o_wb_dest_data, vecs[i].exp_data);
        end
        chk("vec_retired", {28'd0, o_retired}, 32'd9);
        chk("vec_timeout", {31'd0, o_timeout}, 32'd1);

        // Reset while a load is outstanding; the late response must not write.
        i_valid = 1'b1; i_dest_src = S_MEM; i_dest_reg = 5'd3; i_alu_result = 32'h0;
        i_instr = 32'h0000_2000; i_mem_rsp_valid = 1'b0;
        #1 chk("clr_stall0", {31'd0, o_stall}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        #1 chk("clr_stall1", {31'd0, o_stall}, 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        check_regs(1'b0);
        i_valid = 1'b0; i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 32'h7777_7777;
        #1 chk("clr_ready", {31'd0, o_mem_rsp_ready}, 32'd0);
        chk("clr_nostall", {31'd0, o_stall}, 32'd0);
        @(negedge clk);
        check_regs(1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [1:0] s;
            s = ($urandom_range(0, 9) < 5) ? S_MEM : 2'($urandom);
            if ($urandom_range(0, 7) == 0) idle_cycle();
            run_txn(s, 3'($urandom), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                    $urandom, $urandom, $urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
